// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache refill path.
//   cache_state_e   : refill FSM states (IDLE/FETCH/DONE/HOLD)
//   LINE_W          : assembled line width in bits
//   WORD_OFF_LSB    : lowest address bit of the word-in-line index
//   LINE_OFF_LSB    : lowest address bit of the line base
//   DEFAULT_TIMEOUT : default per-beat ack wait limit, in cycles
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } cache_state_e;

    localparam int LINE_W          = 128;
    localparam int WORD_OFF_LSB    = 2;
    localparam int LINE_OFF_LSB    = 4;
    localparam int DEFAULT_TIMEOUT = 255;

endpackage : cache_pkg

// File: rtl/refill_line_buf.sv
// -----------------------------------------------------------------------------
// refill_line_buf
// WORDS x DATA_W line register. One word slot is written per enabled cycle;
// all slots clear on reset. The concatenated line is always visible.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   we_i    : write enable for slot_i
//   slot_i  : word slot to write
//   wdata_i : word to store
//   line_o  : concatenated line, slot i at bits [DATA_W*i +: DATA_W]
// -----------------------------------------------------------------------------
module refill_line_buf #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we_i,
    input  logic [$clog2(WORDS)-1:0]   slot_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W*WORDS-1:0]    line_o
);

    logic [DATA_W-1:0] word_q [WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                word_q[i] <= '0;
            end
        end else if (we_i) begin
            word_q[slot_i] <= wdata_i;
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_line
        assign line_o[g*DATA_W +: DATA_W] = word_q[g];
    end

endmodule : refill_line_buf

// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
// Miss handler downstream of cache_Mem. On a miss it fetches the 4-word line
// from backing memory one word per request/ack beat, assembles it into
// replaceData and pulses refill_valid. A beat whose ack does not arrive within
// TIMEOUT cycles aborts the refill with a refill_err pulse.
//
// Handshake: mem_req/mem_addr are registered and held until a cycle in which
// mem_ack=1; that cycle transfers mem_rdata for the word at mem_addr. The next
// address is presented the following cycle with mem_req still high, so
// back-to-back acks move one word per cycle.
//
// Optional build macro: CRITICAL_WORD_FIRST_EN -- fetch starts at the word
// selected by miss_addr[3:2] and wraps; each word still lands in its own slot.
//
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   miss         : level miss from cache_Mem, held until the line is installed
//   miss_addr    : byte address of the missing access
//   busy         : high in every state except IDLE
//   mem_req      : backing-memory request strobe
//   mem_addr     : word-aligned address of the current beat
//   mem_rdata    : read data, valid with mem_ack
//   mem_ack      : beat accepted
//   replaceData  : assembled line, word i at bits [32i+31:32i]
//   refill_valid : one-cycle pulse, replaceData complete
//   refill_err   : one-cycle pulse, a beat timed out
//   dbg_state_o  : current FSM state
// -----------------------------------------------------------------------------
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int TIMEOUT        = DEFAULT_TIMEOUT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             miss,
    input  logic [ADDR_W-1:0]                miss_addr,
    output logic                             busy,
    output logic                             mem_req,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic [DATA_W-1:0]                mem_rdata,
    input  logic                             mem_ack,
    output logic [DATA_W*WORDS_PER_LINE-1:0] replaceData,
    output logic                             refill_valid,
    output logic                             refill_err,
    output cache_state_e                     dbg_state_o
);

    localparam int BEAT_W = $clog2(WORDS_PER_LINE);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int BASE_W = ADDR_W - LINE_OFF_LSB;

    cache_state_e        state_q, state_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                refill_valid_q, refill_valid_d;
    logic                refill_err_q, refill_err_d;

    logic                beat_ack;
    logic                tmo_hit;
    logic                last_beat;
    logic [BEAT_W-1:0]   cur_slot;
    logic [BEAT_W-1:0]   next_slot;

    // A beat only counts while the request is actually on the bus; acks in
    // any other cycle are ignored.
    assign beat_ack  = (state_q == FETCH) && mem_req_q && mem_ack;
    // The hit fires on the TIMEOUT-th consecutive unacked cycle of a beat.
    assign tmo_hit   = (state_q == FETCH) && mem_req_q && !mem_ack &&
                       (tmo_q == TMO_W'(TIMEOUT - 1));
    assign last_beat = (beat_q == BEAT_W'(WORDS_PER_LINE - 1));

`ifdef CRITICAL_WORD_FIRST_EN
    logic [BEAT_W-1:0] crit_q, crit_d;
    logic              unused_addr_bits;

    // Beat counter is an offset from the critical word, wrapping mod line.
    assign cur_slot         = beat_q + crit_q;
    assign next_slot        = beat_d + crit_q;
    assign crit_d           = (state_q == IDLE && miss) ?
                              miss_addr[LINE_OFF_LSB-1:WORD_OFF_LSB] : crit_q;
    assign unused_addr_bits = ^miss_addr[WORD_OFF_LSB-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crit_q <= '0;
        end else begin
            crit_q <= crit_d;
        end
    end
`else
    logic unused_addr_bits;

    assign cur_slot         = beat_q;
    assign next_slot        = beat_d;
    assign unused_addr_bits = ^miss_addr[LINE_OFF_LSB-1:0];
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (miss) state_d = FETCH;
            FETCH: begin
                if (beat_ack && last_beat) state_d = DONE;
                else if (tmo_hit)          state_d = HOLD;
            end
            DONE:  state_d = HOLD;
            HOLD:  if (!miss) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / datapath next values ----------------
    always_comb begin
        base_d         = base_q;
        beat_d         = beat_q;
        tmo_d          = tmo_q;
        mem_addr_d     = mem_addr_q;
        // The request goes up one cycle after entering FETCH, once the
        // latched base is available, and drops on the terminating edge.
        mem_req_d      = (state_q == FETCH) && (state_d == FETCH);
        refill_valid_d = (state_d == DONE);
        refill_err_d   = tmo_hit;

        if (state_q == IDLE) begin
            tmo_d = '0;
            if (miss) begin
                base_d = miss_addr[ADDR_W-1:LINE_OFF_LSB];
                beat_d = '0;
            end
        end

        if (beat_ack) begin
            beat_d = beat_q + 1'b1;
            tmo_d  = '0;
        end else if (state_q == FETCH && mem_req_q) begin
            tmo_d = tmo_hit ? '0 : tmo_q + 1'b1;
        end

        if (mem_req_d) begin
            mem_addr_d = {base_q, next_slot, {WORD_OFF_LSB{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q         <= '0;
            beat_q         <= '0;
            tmo_q          <= '0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            refill_valid_q <= 1'b0;
            refill_err_q   <= 1'b0;
        end else begin
            base_q         <= base_d;
            beat_q         <= beat_d;
            tmo_q          <= tmo_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            refill_valid_q <= refill_valid_d;
            refill_err_q   <= refill_err_d;
        end
    end

    refill_line_buf #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS_PER_LINE)
    ) u_line_buf (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (beat_ack),
        .slot_i  (cur_slot),
        .wdata_i (mem_rdata),
        .line_o  (replaceData)
    );

    assign busy         = (state_q != IDLE);
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign refill_valid = refill_valid_q;
    assign refill_err   = refill_err_q;
    assign dbg_state_o  = state_q;

endmodule : cache_refill_ctrl

// File: tb/tb_cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_ctrl
// Directed bench for cache_refill_ctrl. Stimulus pushes the expected refill
// outcome (pulse kind, line, latency from the miss-sampling edge) into
// queues; a monitor pops and compares whenever refill_valid or refill_err
// pulses. A task models the backing memory with a configurable ack delay.
// -----------------------------------------------------------------------------
module tb_cache_refill_ctrl;
    import cache_pkg::*;

    localparam logic [1:0] K_VALID = 2'b01;
    localparam logic [1:0] K_ERR   = 2'b10;

    logic         clk;
    logic         rst_n;
    logic         miss;
    logic [31:0]  miss_addr;
    logic         busy;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_rdata;
    logic         mem_ack;
    logic [127:0] replaceData;
    logic         refill_valid;
    logic         refill_err;
    cache_state_e dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;

    logic [1:0]   exp_kind_q[$];
    logic [127:0] exp_line_q[$];
    logic [31:0]  exp_lat_q[$];

    logic [1:0]   m_kind;
    logic [127:0] m_line;
    logic [31:0]  m_lat;

    cache_refill_ctrl dut (
        .clk          (clk),
        .reset        (rst_n),
        .miss         (miss),
        .miss_addr    (miss_addr),
        .busy         (busy),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .replaceData  (replaceData),
        .refill_valid (refill_valid),
        .refill_err   (refill_err),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [127:0] line, input logic [31:0] lat);
        exp_kind_q.push_back(kind);
        exp_line_q.push_back(line);
        exp_lat_q.push_back(lat);
    endtask

    task automatic start_miss(input logic [31:0] addr);
        @(negedge clk);
        miss      = 1'b1;
        miss_addr = addr;
        @(negedge clk);
        t0 = cyc;   // edge count of the edge that sampled the miss
    endtask

    task automatic drop_miss();
        @(negedge clk);
        miss = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_drop", 128'(dbg_state), 128'(IDLE));
    endtask

    // Serves nbeats beats; each beat is acked after 'waits' unacked cycles.
    // addrs holds the required beat addresses, beat b at [32b +: 32].
    task automatic serve_line(input int waits, input int nbeats,
                              input logic [127:0] line, input logic [127:0] addrs);
        for (int b = 0; b < nbeats; b++) begin
            int guard = 0;
            logic [31:0] ea;
            ea = addrs[b*32 +: 32];
            while (!mem_req && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            chk("mem_req_up", 128'(mem_req), 128'(1));
            for (int w = 0; w < waits; w++) begin
                chk("mem_addr_wait", 128'(mem_addr), 128'(ea));
                mem_rdata = $urandom;
                @(negedge clk);
            end
            chk("mem_addr", 128'(mem_addr), 128'(ea));
            mem_ack   = 1'b1;
            mem_rdata = line[mem_addr[3:2]*32 +: 32];
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end
    endtask

    task automatic wait_drain(input int budget);
        int g = 0;
        while (exp_kind_q.size() != 0 && g < budget) begin
            @(negedge clk);
            g++;
        end
        chk("scoreboard_drain", 128'(exp_kind_q.size()), 128'(0));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && (refill_valid || refill_err)) begin
            if (exp_kind_q.size() == 0) begin
                chk("unexpected_pulse", 128'({refill_err, refill_valid}), 128'(0));
            end else begin
                m_kind = exp_kind_q.pop_front();
                m_line = exp_line_q.pop_front();
                m_lat  = exp_lat_q.pop_front();
                chk("pulse_kind", 128'({refill_err, refill_valid}), 128'(m_kind));
                chk("replaceData", replaceData, m_line);
                chk("latency", 128'(cyc - t0), 128'(m_lat));
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [127:0] LINE1 = 128'heeee_ffff_cccc_dddd_aaaa_bbbb_8888_9999;
    localparam logic [127:0] LINE2 = 128'h4444_0004_3333_0003_2222_0002_1111_0001;
    localparam logic [127:0] LINE3 = 128'h0bad_f00d_dead_beef_cafe_babe_1234_5678;
    localparam logic [127:0] LINE4 = 128'h7777_7777_6666_6666_5555_5555_a5a5_5a5a;

    initial begin
        int req_seen;
        logic [127:0] cw_addrs;

        rst_n     = 1'b0;
        miss      = 1'b0;
        miss_addr = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        #2;
        chk("rst_busy",         128'(busy),         128'(0));
        chk("rst_mem_req",      128'(mem_req),      128'(0));
        chk("rst_mem_addr",     128'(mem_addr),     128'(0));
        chk("rst_replaceData",  replaceData,        128'(0));
        chk("rst_refill_valid", 128'(refill_valid), 128'(0));
        chk("rst_refill_err",   128'(refill_err),   128'(0));
        chk("rst_state",        128'(dbg_state),    128'(IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait refill: ack edges 2..5, valid after edge 5.
        push_exp(K_VALID, LINE1, 5);
        start_miss(32'h0000_0003);
        chk("busy_fetch", 128'(busy), 128'(1));
        serve_line(0, 4, LINE1, {32'hC, 32'h8, 32'h4, 32'h0});
        wait_drain(20);
        drop_miss();

        // Two wait cycles before every ack: 8 extra cycles.
        push_exp(K_VALID, LINE1, 13);
        start_miss(32'h0000_0003);
        serve_line(2, 4, LINE1, {32'hC, 32'h8, 32'h4, 32'h0});
        wait_drain(20);
        drop_miss();

        // Miss held high after completion must not retrigger.
        push_exp(K_VALID, LINE2, 5);
        start_miss(32'h0000_0040);
        serve_line(0, 4, LINE2, {32'h4C, 32'h48, 32'h44, 32'h40});
        wait_drain(20);
        req_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req) req_seen++;
        end
        chk("held_miss_no_req", 128'(req_seen), 128'(0));
        chk("held_miss_state", 128'(dbg_state), 128'(HOLD));
        chk("held_miss_busy", 128'(busy), 128'(1));
        drop_miss();
        push_exp(K_VALID, LINE3, 5);
        start_miss(32'h0000_0050);
        serve_line(0, 4, LINE3, {32'h5C, 32'h58, 32'h54, 32'h50});
        wait_drain(20);
        drop_miss();

        // No ack at all: error after 255 unacked cycles, line untouched.
        push_exp(K_ERR, LINE3, 256);
        start_miss(32'h0000_0060);
        wait_drain(400);
        repeat (5) @(negedge clk);
        chk("timeout_state", 128'(dbg_state), 128'(HOLD));
        chk("timeout_req_low", 128'(mem_req), 128'(0));
        drop_miss();

        // Reset in the middle of a refill after two beats.
        start_miss(32'h0000_0070);
        serve_line(0, 2, LINE4, {32'h7C, 32'h78, 32'h74, 32'h70});
        rst_n = 1'b0;
        miss  = 1'b0;
        #1;
        chk("midrst_busy",         128'(busy),         128'(0));
        chk("midrst_mem_req",      128'(mem_req),      128'(0));
        chk("midrst_mem_addr",     128'(mem_addr),     128'(0));
        chk("midrst_replaceData",  replaceData,        128'(0));
        chk("midrst_refill_valid", 128'(refill_valid), 128'(0));
        chk("midrst_state",        128'(dbg_state),    128'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_exp(K_VALID, LINE4, 5);
        start_miss(32'h0000_0070);
        serve_line(0, 4, LINE4, {32'h7C, 32'h78, 32'h74, 32'h70});
        wait_drain(20);
        drop_miss();

        // Miss on word 2 of line 0x100: order depends on the build option.
`ifdef CRITICAL_WORD_FIRST_EN
        cw_addrs = {32'h104, 32'h100, 32'h10C, 32'h108};
`else
        cw_addrs = {32'h10C, 32'h108, 32'h104, 32'h100};
`endif
        push_exp(K_VALID, LINE2, 5);
        start_miss(32'h0000_0108);
        serve_line(0, 4, LINE2, cw_addrs);
        wait_drain(20);
        drop_miss();

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 128'(exp_kind_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cache_refill_ctrl
